rr_arbiter4: RTL

- Four-requester round-robin arbiter with registered one-hot grant. Shares one 4-input pull-down/NOR-style resource among four requesters.
- Requester activity is detected with a 4-input NOR of REQ (any-request = ~NOR4(REQ)).
- Adds grant hold, explicit release, maximum-hold preemption and a break-before-make dead cycle between owners.
- Sits between requesting logic and the shared resource's enable inputs.

---
 rtl/rr_arbiter4.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//
// Four-requester round-robin arbiter guarding one shared resource. The grant is
// registered and one-hot. An owner keeps the grant until it drops its request,
// pulses REL, or (while someone else is waiting) uses up MAX_HOLD cycles. Every
// hand-over passes through one dead cycle with no grant (break-before-make).
//
// Parameters
//   MAX_HOLD : grant cycles before forced preemption under contention (1..255)
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports
//   CLK     in   rising-edge clock
//   RST     in   asynchronous active-high reset
//   REQ     in   [3:0] request vector, bit i = requester i
//   REL     in   owner gives up the grant this cycle (only used while granted)
//   GNT     out  [3:0] registered one-hot grant, 0000 when nobody owns it
//   GNT_VLD out  registered, always |GNT
//   OWNER   out  [1:0] registered index of current / most recent owner
//   TMO     out  one-cycle pulse in the dead cycle after a forced preemption
//   IDLE    out  registered, 1 only while the arbiter is idle
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       REL,
    output logic [3:0] GNT,
    output logic       GNT_VLD,
    output logic [1:0] OWNER,
    output logic       TMO,
    output logic       IDLE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Last value the hold counter reaches; it saturates here.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_reg,    state_next;
    logic [1:0]        ptr_reg,      ptr_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0]        gnt_reg,      gnt_next;
    logic [1:0]        owner_reg,    owner_next;
    logic              tmo_reg,      tmo_next;
    logic              idle_reg,     idle_next;
    logic              gnt_vld_reg,  gnt_vld_next;

    // -------------------------------------------------------------------------
    // Request detection: any request is the inverse of a 4-input NOR.
    // -------------------------------------------------------------------------
    logic req_nor;
    logic any_req;

    assign req_nor = ~|REQ;
    assign any_req = ~req_nor;

    // -------------------------------------------------------------------------
    // Rotating priority: slot gi holds requester (PTR + gi) mod 4, so slot 0 is
    // the highest priority and slot 3 the lowest.
    // -------------------------------------------------------------------------
    logic [1:0] rot_idx [4];
    logic [3:0] rot_req;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
            assign rot_idx[gi] = ptr_reg + 2'(gi);
            assign rot_req[gi] = REQ[rot_idx[gi]];
        end
    endgenerate

    logic [1:0] win_idx;

    always_comb begin
        win_idx = rot_idx[3];
        if (rot_req[0]) begin
            win_idx = rot_idx[0];
        end else if (rot_req[1]) begin
            win_idx = rot_idx[1];
        end else if (rot_req[2]) begin
            win_idx = rot_idx[2];
        end
    end

    // One-hot of the winner; all zero when nobody requests.
    logic [3:0] win_onehot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win_onehot
            assign win_onehot[gi] = any_req && (win_idx == 2'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Release causes while granted. gnt_reg is the owner's one-hot in S_GRANT.
    // -------------------------------------------------------------------------
    logic rel_drop;     // owner no longer requests
    logic rel_timeout;  // hold budget spent while another requester waits
    logic release_now;

    assign rel_drop    = ~REQ[owner_reg];
    assign rel_timeout = (hold_cnt_reg == HOLD_LAST) && ((REQ & ~gnt_reg) != 4'b0000);
    assign release_now = rel_drop || REL || rel_timeout;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        gnt_next      = gnt_reg;
        owner_next    = owner_reg;
        tmo_next      = 1'b0;

        case (state_reg)
            S_IDLE, S_GAP: begin
                if (any_req) begin
                    state_next    = S_GRANT;
                    gnt_next      = win_onehot;
                    owner_next    = win_idx;
                    hold_cnt_next = '0;
                end else begin
                    state_next = S_IDLE;
                    gnt_next   = 4'b0000;
                end
            end

            S_GRANT: begin
                if (release_now) begin
                    state_next = S_GAP;
                    gnt_next   = 4'b0000;
                    // Released owner drops to the lowest priority.
                    ptr_next   = owner_reg + 2'd1;
                    // Only a pure preemption is flagged; a voluntary release
                    // in the same cycle masks it.
                    tmo_next   = rel_timeout && !rel_drop && !REL;
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
                gnt_next   = 4'b0000;
            end
        endcase

        idle_next    = (state_next == S_IDLE);
        gnt_vld_next = |gnt_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= 2'd0;
            hold_cnt_reg <= '0;
            gnt_reg      <= 4'b0000;
            owner_reg    <= 2'd0;
            tmo_reg      <= 1'b0;
            idle_reg     <= 1'b1;
            gnt_vld_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            tmo_reg      <= tmo_next;
            idle_reg     <= idle_next;
            gnt_vld_reg  <= gnt_vld_next;
        end
    end

    assign GNT     = gnt_reg;
    assign GNT_VLD = gnt_vld_reg;
    assign OWNER   = owner_reg;
    assign TMO     = tmo_reg;
    assign IDLE    = idle_reg;

endmodule
